imem_loader: RTL and testbench

- Program loader that fills instruction memory before the single-cycle core runs.
- Accepts a byte stream over a valid/ready handshake and packs every four bytes big-endian into one 32-bit instruction word.
- Writes each word to the next word-aligned instruction-memory address over a write/ack handshake.
- Holds the core in reset while a session is active, then pulses a done flag.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream big-endian into 32-bit words and writes
// them to consecutive word addresses of instruction memory while holding the core.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 64
) (
   input  logic              SYS_clk,
   input  logic              SYS_reset,
   input  logic              LD_start,
   input  logic              LD_end,
   input  logic              LD_byte_valid,
   input  logic [7:0]        LD_byte,
   output logic              LD_byte_ready,
   output logic              IMEM_wr_en,
   output logic [ADDR_W-1:0] IMEM_wr_addr,
   output logic [31:0]       IMEM_wr_data,
   input  logic              IMEM_wr_ack,
   output logic              LD_cpu_hold,
   output logic              LD_busy,
   output logic              LD_done,
   output logic [6:0]        LD_word_count,
   output logic              LD_error,
   output logic [1:0]        LD_dbg_state
);

   // Byte handshake: a byte moves when LD_byte_valid & LD_byte_ready on a rising
   // edge; write handshake: a word moves when IMEM_wr_en & IMEM_wr_ack on a rising edge.
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [6:0] L_MAX = 7'(MAX_WORDS);

   logic [1:0]        r_state;
   logic [1:0]        r_byte_cnt;
   logic [31:0]       r_data;
   logic [ADDR_W-1:0] r_addr;
   logic [6:0]        r_word_count;
   logic              r_error;
   logic              r_end_pending;

   logic              w_accept;
   logic              w_full;
   logic              w_store;
   logic [2:0]        w_cnt_next;
   logic [31:0]       w_lane;
   logic [ADDR_W:0]   w_addr_sum;

   assign w_accept   = (r_state == S_COLLECT) && LD_byte_valid;
   assign w_full     = (r_word_count == L_MAX);
   assign w_store    = w_accept && !w_full;
   assign w_cnt_next = {1'b0, r_byte_cnt} + {2'b00, w_store};
   assign w_lane     = {LD_byte, 24'h000000} >> {r_byte_cnt, 3'b000};
   // The carry bit marks the last word address; the address then holds rather than wraps.
   assign w_addr_sum = {1'b0, r_addr} + (ADDR_W+1)'(4);

   always_ff @(posedge SYS_clk or negedge SYS_reset) begin
      if (!SYS_reset) begin
         r_state       <= S_IDLE;
         r_byte_cnt    <= 2'd0;
         r_data        <= 32'h0;
         r_addr        <= '0;
         r_word_count  <= 7'd0;
         r_error       <= 1'b0;
         r_end_pending <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (LD_start) begin
                  r_state       <= S_COLLECT;
                  r_byte_cnt    <= 2'd0;
                  r_data        <= 32'h0;
                  r_addr        <= '0;
                  r_word_count  <= 7'd0;
                  r_error       <= 1'b0;
                  r_end_pending <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (w_accept && w_full) begin
                  r_error <= 1'b1;
               end
               if (w_store) begin
                  r_data     <= r_data | w_lane;
                  r_byte_cnt <= w_cnt_next[1:0];
               end
               if (w_cnt_next == 3'd4) begin
                  r_state       <= S_WRITE;
                  r_end_pending <= LD_end;
               end else if (LD_end) begin
                  if (w_cnt_next == 3'd0) begin
                     r_state <= S_DONE;
                  end else begin
                     // Low bytes of a partial word are already zero from the last clear.
                     r_error       <= 1'b1;
                     r_end_pending <= 1'b1;
                     r_state       <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (IMEM_wr_ack) begin
                  r_addr       <= w_addr_sum[ADDR_W] ? r_addr : w_addr_sum[ADDR_W-1:0];
                  r_word_count <= w_full ? r_word_count : r_word_count + 7'd1;
                  r_byte_cnt   <= 2'd0;
                  r_data       <= 32'h0;
                  r_state      <= r_end_pending ? S_DONE : S_COLLECT;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign LD_byte_ready = (r_state == S_COLLECT);
   assign IMEM_wr_en    = (r_state == S_WRITE);
   assign LD_done       = (r_state == S_DONE);
   assign LD_busy       = (r_state != S_IDLE);
   assign LD_cpu_hold   = (r_state != S_IDLE);
   assign IMEM_wr_addr  = r_addr;
   assign IMEM_wr_data  = r_data;
   assign LD_word_count = r_word_count;
   assign LD_error      = r_error;
   assign LD_dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed load sessions checked against a
// session-level model of the expected writes, word count and error flag.
module tb_imem_loader;

   localparam int TB_MAX = 2;
   localparam int ADDR_W = 8;

   logic              SYS_clk;
   logic              SYS_reset;
   logic              LD_start;
   logic              LD_end;
   logic              LD_byte_valid;
   logic [7:0]        LD_byte;
   logic              LD_byte_ready;
   logic              IMEM_wr_en;
   logic [ADDR_W-1:0] IMEM_wr_addr;
   logic [31:0]       IMEM_wr_data;
   logic              IMEM_wr_ack;
   logic              LD_cpu_hold;
   logic              LD_busy;
   logic              LD_done;
   logic [6:0]        LD_word_count;
   logic              LD_error;
   logic [1:0]        LD_dbg_state;

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(TB_MAX)) dut (
      .SYS_clk       (SYS_clk),
      .SYS_reset     (SYS_reset),
      .LD_start      (LD_start),
      .LD_end        (LD_end),
      .LD_byte_valid (LD_byte_valid),
      .LD_byte       (LD_byte),
      .LD_byte_ready (LD_byte_ready),
      .IMEM_wr_en    (IMEM_wr_en),
      .IMEM_wr_addr  (IMEM_wr_addr),
      .IMEM_wr_data  (IMEM_wr_data),
      .IMEM_wr_ack   (IMEM_wr_ack),
      .LD_cpu_hold   (LD_cpu_hold),
      .LD_busy       (LD_busy),
      .LD_done       (LD_done),
      .LD_word_count (LD_word_count),
      .LD_error      (LD_error),
      .LD_dbg_state  (LD_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial SYS_clk = 1'b0;
   always #5 SYS_clk = ~SYS_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // {address, data} of each write still expected from the DUT
   logic [39:0] exp_q[$];
   logic [7:0]  sess_bytes[$];

   int ack_mode   = -1;
   bit ack_block  = 1'b0;
   int cur_delay  = 0;
   int acks_seen  = 0;
   int wr_cycles  = 0;

   task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge SYS_clk);
      #1;
   endtask

   // ---------------- memory-side responder ----------------
   initial begin
      bit in_write;
      int wait_cnt;
      in_write = 1'b0;
      wait_cnt = 0;
      IMEM_wr_ack = 1'b0;
      forever begin
         @(posedge SYS_clk);
         #1;
         if (IMEM_wr_en && !ack_block) begin
            if (!in_write) begin
               in_write  = 1'b1;
               wait_cnt  = 0;
               cur_delay = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
            end
            if (wait_cnt >= cur_delay) begin
               IMEM_wr_ack = 1'b1;
               in_write    = 1'b0;
            end else begin
               IMEM_wr_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            IMEM_wr_ack = 1'b0;
            in_write    = 1'b0;
         end
      end
   end

   // ---------------- write scoreboard ----------------
   always @(negedge SYS_clk) begin
      if (SYS_reset && IMEM_wr_en) begin
         wr_cycles++;
         check("wr_ready_low", LD_byte_ready, 1'b0);
         check("wr_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            check("wr_addr_data", {IMEM_wr_addr, IMEM_wr_data}, exp_q[0]);
         end
         if (IMEM_wr_ack) begin
            check("wr_hold_cycles", wr_cycles, cur_delay + 1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            acks_seen++;
            wr_cycles = 0;
         end
      end else begin
         wr_cycles = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready(input string tag);
      int budget;
      budget = 0;
      while (!LD_byte_ready && budget < 50) begin
         tick();
         budget++;
      end
      if (!LD_byte_ready) check(tag, LD_byte_ready, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit with_end);
      wait_ready("ready_timeout");
      LD_byte_valid = 1'b1;
      LD_byte       = b;
      LD_end        = with_end;
      tick();
      LD_byte_valid = 1'b0;
      LD_end        = 1'b0;
      LD_byte       = 8'($urandom);
   endtask

   task automatic pulse_start();
      LD_start = 1'b1;
      tick();
      LD_start = 1'b0;
   endtask

   // Runs one session over sess_bytes; the model derives writes from the byte count alone.
   task automatic run_session(input bit end_with_last, input bit start_glitch);
      int n, n_store, n_words, idx, budget, acks_before;
      bit exp_err;
      logic [31:0] d;
      n       = sess_bytes.size();
      n_store = (n > 4 * TB_MAX) ? 4 * TB_MAX : n;
      n_words = (n_store + 3) / 4;
      exp_err = (n > 4 * TB_MAX) || (n % 4 != 0);
      for (int w = 0; w < n_words; w++) begin
         d = 32'h0;
         for (int k = 0; k < 4; k++) begin
            idx = 4 * w + k;
            if (idx < n_store) d[31 - 8 * k -: 8] = sess_bytes[idx];
         end
         exp_q.push_back({8'(4 * w), d});
      end
      acks_before = acks_seen;

      pulse_start();
      check("start_busy_hold_ready", {LD_busy, LD_cpu_hold, LD_byte_ready}, 3'b111);
      check("start_clears", {1'b0, LD_word_count, LD_error, IMEM_wr_addr}, 17'h0);

      for (int i = 0; i < n; i++) begin
         int gap;
         bit last_end;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            LD_start = start_glitch;
            tick();
            LD_start = 1'b0;
         end
         last_end = end_with_last && (i == n - 1);
         send_byte(sess_bytes[i], last_end);
         if (i < n_store && (i % 4 == 3 || last_end)) begin
            check("wr_en_latency", IMEM_wr_en, 1'b1);
         end else if (!last_end) begin
            check("collect_ready", LD_byte_ready, 1'b1);
         end
      end

      if (!end_with_last) begin
         wait_ready("end_ready_timeout");
         LD_end = 1'b1;
         tick();
         LD_end = 1'b0;
         check("end_response", {IMEM_wr_en, LD_done}, (n_store % 4 != 0) ? 2'b10 : 2'b01);
      end

      budget = 0;
      while (!LD_done && budget < 60) begin
         tick();
         budget++;
      end
      check("done_seen", LD_done, 1'b1);
      check("done_hold_busy", {LD_cpu_hold, LD_busy}, 2'b11);
      tick();
      check("done_one_cycle", {LD_done, LD_busy, LD_cpu_hold, LD_byte_ready, IMEM_wr_en}, 5'b0);
      check("word_count", LD_word_count, 7'(n_words));
      check("error_flag", LD_error, exp_err);
      check("write_total", acks_seen - acks_before, n_words);
      check("exp_q_drained", exp_q.size(), 0);
   endtask

   task automatic reset_during_write();
      int acks_before;
      logic [31:0] d;
      ack_block = 1'b1;
      sess_bytes.delete();
      for (int i = 0; i < 4; i++) sess_bytes.push_back(8'($urandom));
      d = {sess_bytes[0], sess_bytes[1], sess_bytes[2], sess_bytes[3]};
      exp_q.push_back({8'h00, d});
      acks_before = acks_seen;
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(sess_bytes[i], 1'b0);
      tick();
      tick();
      check("rst_pre_wr_en", IMEM_wr_en, 1'b1);
      #3;
      SYS_reset = 1'b0;
      #1;
      check("rst_async_ctrl", {IMEM_wr_en, LD_byte_ready, LD_busy, LD_cpu_hold, LD_done, LD_error}, 6'b0);
      check("rst_async_data", {IMEM_wr_addr, IMEM_wr_data}, 40'h0);
      check("rst_async_count", LD_word_count, 7'd0);
      exp_q.delete();
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
      tick();
      tick();
      check("rst_release_idle", {LD_byte_ready, IMEM_wr_en, LD_busy}, 3'b000);
      check("rst_no_write", acks_seen - acks_before, 0);
      ack_block = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      SYS_reset     = 1'b0;
      LD_start      = 1'b0;
      LD_end        = 1'b0;
      LD_byte_valid = 1'b0;
      LD_byte       = 8'h00;
      repeat (3) @(posedge SYS_clk);
      #1;
      check("reset_ctrl", {IMEM_wr_en, LD_byte_ready, LD_busy, LD_cpu_hold, LD_done, LD_error}, 6'b0);
      check("reset_data", {IMEM_wr_addr, IMEM_wr_data}, 40'h0);
      check("reset_count", LD_word_count, 7'd0);
      @(negedge SYS_clk);
      SYS_reset = 1'b1;
      tick();
      check("idle_ready_low", LD_byte_ready, 1'b0);

      ack_mode   = 0;
      sess_bytes = '{8'h20, 8'h09, 8'h00, 8'h0A};
      run_session(1'b0, 1'b0);

      ack_mode = 3;
      sess_bytes.delete();
      for (int i = 0; i < 5; i++) sess_bytes.push_back(8'($urandom));
      run_session(1'b0, 1'b0);

      ack_mode   = -1;
      sess_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      run_session(1'b0, 1'b0);

      sess_bytes.delete();
      for (int i = 0; i < 9; i++) sess_bytes.push_back(8'($urandom));
      run_session(1'b0, 1'b0);

      reset_during_write();

      sess_bytes.delete();
      for (int i = 0; i < 8; i++) sess_bytes.push_back(8'($urandom));
      run_session(1'b1, 1'b1);

      for (int s = 0; s < 24; s++) begin
         int n;
         bit ewl;
         n = $urandom_range(0, 11);
         ewl = (n > 0 && n <= 4 * TB_MAX) ? 1'($urandom_range(0, 1)) : 1'b0;
         sess_bytes.delete();
         for (int i = 0; i < n; i++) sess_bytes.push_back(8'($urandom));
         run_session(ewl, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete within 300000 ns");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
